mesh_injector: RTL and testbench
================================

MESH_INJECTOR -- requirements
Module: mesh_injector

Interface
REQ-001 Parameters SHALL be:
- WIDTH, 15, packet width.
- ROW, 4, mesh rows.
- COL, 4, mesh columns.
- X_HOP_LOC, 4, LSB of the x-hop field.
- Y_HOP_LOC, 7, LSB of the y-hop field.
- DEPTH, 4, command FIFO entries (power of 2).
- SYNC_STAGES, 2, flops on the ack synchronizer.

REQ-002 Derived widths SHALL be DW = $clog2(ROW*COL) and PW = WIDTH-Y_HOP_LOC-3 (PW = 5 at defaults).

REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock; one clock for the whole block.
- rst_n, in, 1, reset; asynchronous, active-low.
- in_valid, in, 1, command valid.
- in_ready, out, 1, command ready.
- in_dest, in, DW, destination node index (row*COL+col).
- in_type, in, 2, packet type.
- in_payload, in, PW, payload.
- out_req, out, 1, 4-phase bundled-data request to the mesh injection channel (router ROW-1,0, north input).
- out_ack, in, 1, asynchronous acknowledge from the mesh.
- out_data, out, WIDTH, packet.
- sent_count, out, 16, completed packets.
- err, out, 1, sticky bad-destination flag.
- busy, out, 1, FIFO non-empty or handshake in progress.

Function
REQ-004 A command SHALL be accepted on a rising clk edge where in_valid & in_ready.

REQ-005 in_ready SHALL equal "FIFO not full", registered-state derived, with no combinational path from in_valid.

REQ-006 Packet format SHALL be:
- [1:0] = in_type.
- [3:2] = 2'b00 (east, south).
- [X_HOP_LOC+2:X_HOP_LOC] = in_dest % COL.
- [Y_HOP_LOC+2:Y_HOP_LOC] = ROW-1-(in_dest / COL).
- [WIDTH-1:Y_HOP_LOC+3] = in_payload.

REQ-007 The packet SHALL be formed at acceptance and stored in the FIFO.

REQ-008 A command with in_dest >= ROW*COL SHALL be accepted, discarded (not written to the FIFO), and SHALL set err until reset.

REQ-009 The FIFO SHALL be a circular buffer with wrapping pointers and count 0..DEPTH.
- A push and a pop in the same cycle SHALL leave the count unchanged.
- A push while full SHALL be impossible (in_ready = 0).

REQ-010 out_ack SHALL pass through SYNC_STAGES flops; the result is ack_s. All FSM decisions SHALL use ack_s only.

REQ-011 The FSM SHALL have states IDLE, WAIT_ACK and WAIT_REL.

REQ-012 In IDLE with FIFO non-empty and ack_s = 0, the FSM SHALL at that edge pop the head into out_data, set out_req = 1, and go to WAIT_ACK.

REQ-013 In WAIT_ACK, on ack_s = 1 the FSM SHALL set out_req = 0 and go to WAIT_REL; otherwise it SHALL hold.

REQ-014 In WAIT_REL, on ack_s = 0 the FSM SHALL increment sent_count (wrapping modulo 2^16) and go to IDLE.

REQ-015 out_data SHALL be stable from the out_req rise until the edge that leaves WAIT_REL.

REQ-016 Latency SHALL be: a command accepted at edge k into an empty FIFO with the FSM idle has out_req = 1 after edge k+1.

REQ-017 Back-to-back packets SHALL NOT overlap; the next out_req rise occurs no earlier than the edge after WAIT_REL exits.

REQ-018 busy SHALL equal (count != 0) | (state != IDLE).

Reset
REQ-019 While rst_n = 0, independent of clk, the block SHALL hold: out_req = 0, out_data = 0, sent_count = 0, err = 0, FIFO empty, state IDLE, synchronizer flops 0, in_ready = 0.

REQ-020 The first edge after rst_n rises SHALL set in_ready = 1.

REQ-021 Reset mid-handshake SHALL drop out_req immediately and discard queued commands. Recovery of the mesh-side channel is the system's responsibility.

Verification
REQ-022 Single packet: in_dest = 5, in_type = 01, in_payload = 5'h1A -> out_data = 15'h6911, out_req rises after edge k+1; a responder acks -> out_req falls, sent_count = 1.

REQ-023 Corner node: in_dest = 15, in_type = 10, in_payload = 5'h1F -> out_data = 15'h7C32. Also in_dest = 12, type 00, payload 0 -> out_data = 15'h0000.

REQ-024 Full/backpressure: hold out_ack = 0 and push 6 commands -> 1 command in flight plus 4 in the FIFO; in_ready = 0 after the 5th accept. Release acks -> all 5 delivered in order, sent_count = 5.

REQ-025 Bad destination: ROW = COL = 4, in_dest valid and err path exercised via a parameter override of ROW = 3 with in_dest = 13 -> accepted, no out_req, err = 1, sent_count unchanged.

REQ-026 Handshake ordering: the responder delays the ack rise by 7 cycles and the ack fall by 3 cycles -> out_data constant throughout, no second out_req rise before ack_s = 0, busy = 0 after completion.

REQ-027 Reset mid-transfer: assert rst_n = 0 while in WAIT_ACK with 3 queued -> out_req = 0 and in_ready = 0 within the reset. After release: FIFO empty, sent_count = 0, no further out_req without new commands.

Source files
------------

// File: rtl/mesh_injector.sv
`default_nettype none
// ============================================================================
// mesh_injector : formats commands into mesh packets, queues them, and drives
//                 a 4-phase bundled-data injection channel.   Rev 1.0
// ============================================================================

module mesh_injector #(
  parameter int WIDTH       = 15,
  parameter int ROW         = 4,
  parameter int COL         = 4,
  parameter int X_HOP_LOC   = 4,
  parameter int Y_HOP_LOC   = 7,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  localparam int DW = $clog2(ROW * COL),
  localparam int PW = WIDTH - Y_HOP_LOC - 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_dest,
  input  logic [1:0]       in_type,
  input  logic [PW-1:0]    in_payload,
  output logic             out_req,
  input  logic             out_ack,
  output logic [WIDTH-1:0] out_data,
  output logic [15:0]      sent_count,
  output logic             err,
  output logic             busy
);

  localparam int AW    = $clog2(DEPTH);
  localparam int NODES = ROW * COL;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       mem_q [DEPTH];
  logic [AW-1:0]          wptr_q, rptr_q;
  logic [AW:0]            count_q, count_d;
  logic                   rdy_q, err_q, req_q, req_d;
  logic [WIDTH-1:0]       data_q, data_d;
  logic [15:0]            sent_q, sent_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_s, accept_w, push_w, pop_w, dest_ok_w;
  int unsigned            dest_i;
  logic [2:0]             x_w, y_w;
  logic [WIDTH-1:0]       pkt_w;

  assign dest_i    = 32'(in_dest);
  assign dest_ok_w = dest_i < 32'(NODES);
  assign x_w       = 3'(dest_i % COL);
  assign y_w       = 3'(ROW - 1 - dest_i / COL);

  // Hop directions are always east/south since injection enters at row ROW-1, col 0.
  always_comb begin
    pkt_w                         = '0;
    pkt_w[1:0]                    = in_type;
    pkt_w[X_HOP_LOC +: 3]         = x_w;
    pkt_w[Y_HOP_LOC +: 3]         = y_w;
    pkt_w[WIDTH-1:Y_HOP_LOC+3]    = in_payload;
  end

  assign in_ready = rdy_q & (count_q != (AW+1)'(DEPTH));
  assign accept_w = in_valid & in_ready;
  assign push_w   = accept_w & dest_ok_w;
  assign ack_s    = sync_q[SYNC_STAGES-1];

  always_comb begin
    count_d = count_q;
    case ({push_w, pop_w})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    sent_d  = sent_q;
    pop_w   = 1'b0;
    case (state_q)
      IDLE: begin
        if ((count_q != '0) && !ack_s) begin
          pop_w   = 1'b1;
          data_d  = mem_q[rptr_q];
          req_d   = 1'b1;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (!ack_s) begin
          sent_d  = sent_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_w) mem_q[wptr_q] <= pkt_w;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      sync_q  <= '0;
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      sent_q  <= '0;
    end else begin
      rdy_q   <= 1'b1;
      err_q   <= err_q | (accept_w & ~dest_ok_w);
      wptr_q  <= push_w ? wptr_q + 1'b1 : wptr_q;
      rptr_q  <= pop_w ? rptr_q + 1'b1 : rptr_q;
      count_q <= count_d;
      sync_q  <= {sync_q[SYNC_STAGES-2:0], out_ack};
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      sent_q  <= sent_d;
    end
  end

  assign out_req    = req_q;
  assign out_data   = data_q;
  assign sent_count = sent_q;
  assign err        = err_q;
  assign busy       = (count_q != '0) | (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mesh_injector.sv
`default_nettype none
// ============================================================================
// tb_mesh_injector : self-checking bench for mesh_injector.   Rev 1.0
// ============================================================================

module tb_mesh_injector;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [3:0]  in_dest = '0;
  logic [1:0]  in_type = '0;
  logic [4:0]  in_payload = '0;
  logic        out_req, out_ack, err, busy;
  logic [14:0] out_data;
  logic [15:0] sent_count;

  logic        in_valid3 = 1'b0, in_ready3, out_req3, out_ack3, err3, busy3;
  logic [3:0]  in_dest3 = '0;
  logic [1:0]  in_type3 = '0;
  logic [4:0]  in_payload3 = '0;
  logic [14:0] out_data3;
  logic [15:0] sent_count3;

  int          checks = 0, failures = 0;
  logic [14:0] model_q[$];
  logic [14:0] cur_data, exp_pkt;
  bit          cur_valid = 0, prev_req = 0, req3_seen = 0;
  bit          resp_en = 0, rnd = 0;
  int          rise_dly = 0, fall_dly = 0, rc = 0, base = 0;

  typedef struct {
    logic [3:0]  dest;
    logic [1:0]  typ;
    logic [4:0]  pay;
    logic [14:0] exp;
  } vec_t;
  vec_t tbl[5];

  mesh_injector dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_dest(in_dest), .in_type(in_type), .in_payload(in_payload),
    .out_req(out_req), .out_ack(out_ack), .out_data(out_data),
    .sent_count(sent_count), .err(err), .busy(busy)
  );

  mesh_injector #(.ROW(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_dest(in_dest3), .in_type(in_type3), .in_payload(in_payload3),
    .out_req(out_req3), .out_ack(out_ack3), .out_data(out_data3),
    .sent_count(sent_count3), .err(err3), .busy(busy3)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Packet model for the default 4x4 mesh, straight from the field layout.
  function automatic logic [14:0] ref_pkt(input int d, input int t, input int p);
    return 15'(t + (d % 4) * 16 + (3 - d / 4) * 128 + p * 1024);
  endfunction

  task automatic push(input int d, input int t, input int p);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_dest = 4'(d); in_type = 2'(t); in_payload = 5'(p);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready", 32'(in_ready), 1);
    @(posedge clk);
    model_q.push_back(ref_pkt(d, t, p));
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while ((busy || model_q.size() != 0) && n < maxc);
    chk("drain_done", 32'(busy || model_q.size() != 0), 0);
  endtask

  // Mesh-side responder: ack follows req after programmable delays.
  initial begin
    out_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        out_ack = 1'b0; rc = 0;
      end else if (resp_en) begin
        if (out_req && !out_ack) begin
          if (rc >= rise_dly) begin out_ack = 1'b1; rc = 0; end
          else rc++;
        end else if (!out_req && out_ack) begin
          if (rc >= fall_dly) begin
            out_ack = 1'b0; rc = 0;
            if (rnd) begin
              rise_dly = $urandom_range(0, 5);
              fall_dly = $urandom_range(0, 5);
            end
          end else rc++;
        end
      end
    end
  end

  // Channel monitor: order, payload stability, and no overlap with a live ack.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        prev_req = 0; cur_valid = 0;
      end else begin
        if (out_req && !prev_req) begin
          chk("ack_low_at_req", 32'(out_ack), 0);
          if (model_q.size() == 0) begin
            chk("unexpected_req", 1, 0);
          end else begin
            exp_pkt = model_q.pop_front();
            chk("pkt_order", 32'(out_data), 32'(exp_pkt));
          end
          cur_data = out_data; cur_valid = 1;
        end else if (cur_valid) begin
          chk("data_stable", 32'(out_data), 32'(cur_data));
        end
        prev_req = out_req;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1 if (out_req3) req3_seen = 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{4'd5,  2'd1, 5'h1A, 15'h6911};
    tbl[1] = '{4'd15, 2'd2, 5'h1F, 15'h7C32};
    tbl[2] = '{4'd12, 2'd0, 5'h00, 15'h0000};
    tbl[3] = '{4'd0,  2'd3, 5'h00, 15'h0183};
    tbl[4] = '{4'd6,  2'd0, 5'h01, 15'h0520};

    // Asynchronous reset with no clock edge yet.
    #1 rst_n = 1'b0;
    #3;
    chk("rst_out_req", 32'(out_req), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_sent", 32'(sent_count), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_busy", 32'(busy), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("ready_before_edge", 32'(in_ready), 0);
    @(posedge clk);
    #1 chk("ready_after_edge", 32'(in_ready), 1);

    // Single-packet vectors: latency, format and completion count.
    resp_en = 1; rise_dly = 2; fall_dly = 1;
    for (int i = 0; i < 5; i++) begin
      base = int'(sent_count);
      push(int'(tbl[i].dest), int'(tbl[i].typ), int'(tbl[i].pay));
      @(posedge clk);
      #1 chk("latency_req", 32'(out_req), 1);
      chk("vec_data", 32'(out_data), 32'(tbl[i].exp));
      wait_idle(200);
      chk("vec_sent", 32'(sent_count), 32'(base + 1));
    end

    // Backpressure: 1 in flight + 4 queued, sixth command must be held off.
    resp_en = 0;
    base = int'(sent_count);
    for (int i = 0; i < 5; i++) push(i + 1, i % 4, i * 3);
    chk("full_ready", 32'(in_ready), 0);
    chk("full_busy", 32'(busy), 1);
    @(negedge clk);
    in_valid = 1'b1; in_dest = 4'd9; in_type = 2'd1; in_payload = 5'd7;
    repeat (8) begin
      chk("full_hold", 32'(in_ready), 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("full_inflight", 32'(out_req), 1);
    resp_en = 1;
    wait_idle(600);
    chk("full_sent", 32'(sent_count), 32'(base + 5));

    // Slow handshake: ack rise delayed 7, fall delayed 3, two queued packets.
    rise_dly = 7; fall_dly = 3;
    base = int'(sent_count);
    push(3, 2, 9);
    push(10, 1, 22);
    wait_idle(400);
    chk("slow_busy", 32'(busy), 0);
    chk("slow_sent", 32'(sent_count), 32'(base + 2));

    // Randomized stream with random responder timing.
    rnd = 1; rise_dly = 1; fall_dly = 1;
    base = int'(sent_count);
    for (int i = 0; i < 40; i++) begin
      push($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(posedge clk);
    end
    wait_idle(4000);
    chk("rand_sent", 32'(sent_count), 32'(base + 40));
    rnd = 0; rise_dly = 2; fall_dly = 1;
    chk("no_err", 32'(err), 0);

    // Bad destination on a 3x4 mesh.
    chk("bad_err_before", 32'(err3), 0);
    @(negedge clk);
    in_valid3 = 1'b1; in_dest3 = 4'd13; in_type3 = 2'd1; in_payload3 = 5'd4;
    chk("bad_ready", 32'(in_ready3), 1);
    @(posedge clk);
    #1 in_valid3 = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    chk("bad_err", 32'(err3), 1);
    chk("bad_no_req", 32'(req3_seen), 0);
    chk("bad_sent", 32'(sent_count3), 0);
    chk("bad_busy", 32'(busy3), 0);

    // Reset while in WAIT_ACK with three commands queued.
    resp_en = 0;
    for (int i = 0; i < 4; i++) push(i + 4, 1, i + 10);
    @(posedge clk);
    #1 chk("mid_req", 32'(out_req), 1);
    #2 rst_n = 1'b0;
    model_q.delete();
    #1;
    chk("mid_rst_req", 32'(out_req), 0);
    chk("mid_rst_ready", 32'(in_ready), 0);
    chk("mid_rst_sent", 32'(sent_count), 0);
    chk("mid_rst_err3", 32'(err3), 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    resp_en = 1;
    @(posedge clk);
    #1 chk("post_rst_ready", 32'(in_ready), 1);
    chk("post_rst_busy", 32'(busy), 0);
    repeat (20) @(posedge clk);
    #2;
    chk("post_rst_req", 32'(out_req), 0);
    chk("post_rst_sent", 32'(sent_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
